// File: rtl/nco_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : nco_pkg                                                      |
// | Purpose : Shared constants and types for the NCO / PDM channel array.  |
// |           Holds the per-channel mode encodings, the bit positions of   |
// |           the configuration header fields, the loader FSM state type   |
// |           and the dither LFSR seed, taps and step function.            |
// | Macros  : NCO_DITHER_EN (the LFSR constants are only consumed when it  |
// |           is defined)                                                  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package nco_pkg;

   // Channel accumulation modes
   localparam logic MODE_LEGACY = 1'b0;   // signed add, output = extra acc bit
   localparam logic MODE_CARRY  = 1'b1;   // unsigned add, output = carry out

   // Configuration header byte layout
   localparam int HDR_MODE_BIT = 7;
   localparam int HDR_CH_MSB   = 6;
   localparam int HDR_CH_LSB   = 4;
   localparam int HDR_CLR_BIT  = 3;

   // Dither LFSR: x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
   // Feedback bits 7,5,4,3 correspond to the x^8,x^6,x^5,x^4 terms.
   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } cfg_state_t;

   // One LFSR step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [7:0] lfsr_step(input logic [7:0] state);
      return {state[6:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : nco_channel                                                  |
// | Purpose : One oscillator channel: tuning word, mode bit, an ACC_W+1    |
// |           bit accumulator and its registered PDM output bit.           |
// |                                                                        |
// | Ports   : clk        in   clock, rising edge                           |
// |           rst_n      in   synchronous active-low reset                 |
// |           dither_cin in   carry-in for mode-1 adds (0 when no dither)  |
// |           wr_en      in   commit strobe for this channel               |
// |           wr_clr     in   zero the accumulator on the commit edge      |
// |           wr_mode    in   new mode, captured on the commit edge        |
// |           wr_tw      in   new tuning word, captured on the commit edge |
// |           pdm        out  registered output bit                        |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module nco_channel
   import nco_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dither_cin,
   input  logic             wr_en,
   input  logic             wr_clr,
   input  logic             wr_mode,
   input  logic [ACC_W-1:0] wr_tw,
   output logic             pdm
);

   logic [ACC_W-1:0] tw;
   logic             mode;
   // acc[ACC_W] is the sign/extra bit in legacy mode and the registered
   // carry in carry mode; in both cases it is the channel output.
   logic [ACC_W:0]   acc;

   logic [ACC_W:0]   sum_legacy;
   logic [ACC_W:0]   sum_carry;
   logic [ACC_W:0]   acc_next;

   always_comb begin
      sum_legacy = acc + {tw[ACC_W-1], tw};
      // The previous carry is not fed back: only the low ACC_W bits
      // take part in the add, the MSB of the result is the new carry.
      sum_carry  = {1'b0, acc[ACC_W-1:0]} + {1'b0, tw}
                 + {{ACC_W{1'b0}}, dither_cin};
      acc_next   = (mode == MODE_CARRY) ? sum_carry : sum_legacy;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tw   <= '0;
         mode <= MODE_LEGACY;
         acc  <= '0;
      end else if (wr_en) begin
         // The commit edge still accumulates with the old word and mode;
         // the new values take effect from the following edge.
         tw   <= wr_tw;
         mode <= wr_mode;
         if (wr_clr) begin
            acc <= '0;
         end else if (wr_mode != mode) begin
            // The extra bit means different things in the two modes, so it
            // is dropped while the phase held in the low bits is kept.
            acc <= {1'b0, acc_next[ACC_W-1:0]};
         end else begin
            acc <= acc_next;
         end
      end else begin
         acc <= acc_next;
      end
   end

   assign pdm = acc[ACC_W];

endmodule : nco_channel
`default_nettype wire

// File: rtl/nco_pdm_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : nco_pdm_array                                                |
// | Purpose : Array of N_CH numerically controlled oscillators producing   |
// |           one PDM bit each, configured through a byte-wide valid/ready |
// |           stream: one header byte followed by ACC_W/8 tuning-word      |
// |           bytes (LSB first), committed atomically to one channel.      |
// |                                                                        |
// | Ports   : clk        in   clock, rising edge                           |
// |           rst_n      in   synchronous active-low reset                 |
// |           cfg_valid  in   config byte offered                          |
// |           cfg_data   in   config byte                                  |
// |           cfg_ready  out  config byte accepted when valid & ready      |
// |           pdm_out    out  one registered PDM bit per channel           |
// |           cfg_err    out  sticky: a commit addressed a missing channel |
// |                                                                        |
// | Macros  : NCO_DITHER_EN - adds an 8-bit LFSR whose bit 0 is the        |
// |           carry-in of every carry-mode add. Undefined: carry-in is 0   |
// |           and the array is fully deterministic.                        |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module nco_pdm_array
   import nco_pkg::*;
#(
   parameter int ACC_W = 16,   // multiple of 8, 8..32
   parameter int N_CH  = 4     // 1..8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_valid,
   input  logic [7:0]      cfg_data,
   output logic            cfg_ready,
   output logic [N_CH-1:0] pdm_out,
   output logic            cfg_err
);

   localparam int         N_BYTES   = ACC_W / 8;
   localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

   cfg_state_t       state;
   logic [1:0]       byte_cnt;
   logic [ACC_W-1:0] shadow;
   logic             hdr_mode;
   logic [2:0]       hdr_ch;
   logic             hdr_clr;

   logic             commit;
   logic             ch_ok;
   logic             dither_cin;

   assign commit = (state == ST_COMMIT);
   assign ch_ok  = ({1'b0, hdr_ch} < 4'(N_CH));

   // ------------------------------------------------------------------
   // Loader FSM. cfg_ready is registered: it drops only for the single
   // COMMIT cycle. Reset clears the shadow, so an interrupted load can
   // never reach a channel.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         byte_cnt  <= '0;
         shadow    <= '0;
         hdr_mode  <= MODE_LEGACY;
         hdr_ch    <= '0;
         hdr_clr   <= 1'b0;
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  hdr_mode <= cfg_data[HDR_MODE_BIT];
                  hdr_ch   <= cfg_data[HDR_CH_MSB:HDR_CH_LSB];
                  hdr_clr  <= cfg_data[HDR_CLR_BIT];
                  byte_cnt <= '0;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (cfg_valid) begin
                  for (int b = 0; b < N_BYTES; b++) begin
                     if (byte_cnt == 2'(b)) begin
                        shadow[b*8 +: 8] <= cfg_data;
                     end
                  end
                  if (byte_cnt == LAST_BYTE) begin
                     state     <= ST_COMMIT;
                     cfg_ready <= 1'b0;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            ST_COMMIT: begin
               // Out-of-range channels consumed their bytes; only flag it.
               if (!ch_ok) begin
                  cfg_err <= 1'b1;
               end
               state     <= ST_IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Optional dither source
   // ------------------------------------------------------------------
`ifdef NCO_DITHER_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   assign dither_cin = lfsr[0];
`else
   assign dither_cin = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Channel array
   // ------------------------------------------------------------------
   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic wr_en;

         assign wr_en = commit && ch_ok && (hdr_ch == 3'(i));

         nco_channel #(
            .ACC_W (ACC_W)
         ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .dither_cin (dither_cin),
            .wr_en      (wr_en),
            .wr_clr     (hdr_clr),
            .wr_mode    (hdr_mode),
            .wr_tw      (shadow),
            .pdm        (pdm_out[i])
         );
      end
   endgenerate

endmodule : nco_pdm_array
`default_nettype wire

// File: tb/tb_nco_pdm_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_nco_pdm_array                                             |
// | Purpose : Self-checking bench for nco_pdm_array (ACC_W=16, N_CH=4).    |
// |           A transaction-level model tracks each channel's phase as an  |
// |           integer and compares every cycle; directed sequences cover   |
// |           density, wrap, bad channel, stalls and reset mid-load,       |
// |           followed by randomized packets.                              |
// | Macros  : NCO_DITHER_EN (model follows the RTL build option)           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_nco_pdm_array;

   localparam int ACC_W = 16;
   localparam int N_CH  = 4;
   localparam int NB    = ACC_W / 8;
   localparam int unsigned SPAN  = 65536;    // 2^ACC_W
   localparam int unsigned SPAN2 = 131072;   // 2^(ACC_W+1)

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_valid = 1'b0;
   logic [7:0]      cfg_data = 8'h00;
   logic            cfg_ready;
   logic [N_CH-1:0] pdm_out;
   logic            cfg_err;

   nco_pdm_array #(
      .ACC_W (ACC_W),
      .N_CH  (N_CH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .pdm_out   (pdm_out),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned m_ph [N_CH];   // phase in [0, 2^17): top bit is the output
   int unsigned m_tw [N_CH];
   bit          m_mode [N_CH];
   bit          m_err;
   bit          m_commit;
   int          m_cnt;
   logic [7:0]  m_hdr;
   int unsigned m_shadow;
`ifdef NCO_DITHER_EN
   logic [7:0]  m_lfsr;
`endif

   function automatic int unsigned advance(input int unsigned ph, input int unsigned tw,
                                           input bit mode, input int unsigned cin);
      int sv;
      if (!mode) begin
         sv = (tw >= SPAN/2) ? int'(tw) - int'(SPAN) : int'(tw);
         return int'(unsigned'((int'(ph) + sv + int'(SPAN2)) % int'(SPAN2)));
      end
      return (ph % SPAN) + tw + cin;
   endfunction

   function automatic logic [N_CH-1:0] m_out();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = (m_ph[c] >= SPAN);
      return v;
   endfunction

   always @(posedge clk) begin : model
      int unsigned cin;
      int          ch;
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            m_ph[c] = 0; m_tw[c] = 0; m_mode[c] = 1'b0;
         end
         m_err = 1'b0; m_commit = 1'b0; m_cnt = 0; m_hdr = 8'h00; m_shadow = 0;
`ifdef NCO_DITHER_EN
         m_lfsr = 8'h01;
`endif
      end else begin
         cin = 0;
`ifdef NCO_DITHER_EN
         cin = m_lfsr[0];
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
         for (int c = 0; c < N_CH; c++) m_ph[c] = advance(m_ph[c], m_tw[c], m_mode[c], cin);
         if (m_commit) begin
            ch = int'(m_hdr[6:4]);
            if (ch >= N_CH) m_err = 1'b1;
            else begin
               if (m_hdr[3]) m_ph[ch] = 0;
               else if (m_mode[ch] != m_hdr[7]) m_ph[ch] = m_ph[ch] % SPAN;
               m_tw[ch]   = m_shadow;
               m_mode[ch] = m_hdr[7];
            end
            m_commit = 1'b0;
            m_cnt    = 0;
         end else if (cfg_valid) begin
            if (m_cnt == 0) begin
               m_hdr = cfg_data; m_shadow = 0;
            end else begin
               m_shadow = m_shadow + (int'(cfg_data) << (8 * (m_cnt - 1)));
            end
            m_cnt++;
            if (m_cnt == 1 + NB) m_commit = 1'b1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   bit mon_en = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         chk("pdm_out",   32'(pdm_out),   32'(m_out()));
         chk("cfg_ready", 32'(cfg_ready), 32'(!m_commit));
         chk("cfg_err",   32'(cfg_err),   32'(m_err));
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic put(input logic [7:0] b);
      int n = 0;
      while (m_commit && n < 4) begin
         @(negedge clk);
         n++;
      end
      cfg_valid = 1'b1;
      cfg_data  = b;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] hdr, input logic [15:0] tw);
      put(hdr);
      put(tw[7:0]);
      put(tw[15:8]);
   endtask

   task automatic pulse_reset(input int n);
      rst_n = 1'b0;
      idle(n);
      rst_n = 1'b1;
   endtask

   int ones;
   logic [7:0]  hdr;
   logic [15:0] tw;

   initial begin
      mon_en = 1'b1;
      rst_n  = 1'b0;
      idle(2);
      rst_n  = 1'b1;
      chk("rst_pdm",   32'(pdm_out),   32'h0);
      chk("rst_err",   32'(cfg_err),   32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h1);

      // Carry mode on ch0, TW = 0x4000: one carry every fourth cycle
      load(8'h80, 16'h4000);
      idle(1);
      ones = 0;
      repeat (16) begin
         @(negedge clk);
         ones += int'(pdm_out[0]);
      end
      chk("ch0_density", 32'(ones), 32'd4);
      chk("others_quiet", 32'(pdm_out[3:1]), 32'h0);

      // Legacy mode on ch1 with phase clear, TW = -128
      load(8'h18, 16'hFF80);
      idle(1);
      chk("ch1_cleared", 32'(pdm_out[1]), 32'h0);
      ones = 0;
      repeat (512) begin
         @(negedge clk);
         ones += int'(pdm_out[1]);
      end
      chk("ch1_high512", 32'(ones), 32'd512);
      idle(1);
      chk("ch1_drops", 32'(pdm_out[1]), 32'h0);

      // Nonexistent channel 5: bytes consumed, error flagged
      load(8'h50, 16'h1234);
      idle(1);
      chk("bad_ch_err", 32'(cfg_err), 32'h1);

      // Following valid load: carry mode, TW = 0 on ch2 stays silent
      load(8'hA0, 16'h0000);
      idle(1);
      chk("after_err_ready", 32'(cfg_ready), 32'h1);
      ones = 0;
      repeat (1000) begin
         @(negedge clk);
         ones += int'(pdm_out[2]);
      end
      chk("tw0_quiet", 32'(ones), 32'd0);

      // Stall mid-LOAD, then reset before the commit
      put(8'h38);
      put(8'h55);
      idle(3);
      pulse_reset(1);
      chk("midload_ready", 32'(cfg_ready), 32'h1);
      chk("midload_pdm",   32'(pdm_out),   32'h0);
      chk("midload_err",   32'(cfg_err),   32'h0);
      idle(40);
      chk("midload_no_tw", 32'(pdm_out), 32'h0);

      // Randomized packets with gaps and occasional resets
      repeat (250) begin
         idle($urandom_range(0, 12));
         hdr = 8'($urandom);
         hdr[6:4] = 3'($urandom_range(0, 4));
         tw  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) tw = 16'($urandom_range(0, 600)) ^ {16{tw[15]}};
         put(hdr);
         idle($urandom_range(0, 3));
         put(tw[7:0]);
         if ($urandom_range(0, 24) == 0) begin
            pulse_reset($urandom_range(1, 2));
         end else begin
            idle($urandom_range(0, 3));
            put(tw[15:8]);
         end
      end

      idle(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_nco_pdm_array
`default_nettype wire
